// File: rtl/mod_inverse.sv
// ---------------------------------------------------------------------------
// mod_inverse
// Sequential extended-Euclid engine. It computes d = e^-1 mod phi using
// subtraction only, one subtract per clock. It also reports gcd(e, phi) and
// whether the inverse exists.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous, active-high reset
//   start    in   request; only sampled while idle
//   e        in   [W-1:0] public exponent, latched on accepted start
//   phi      in   [W-1:0] modulus (totient), latched on accepted start
//   busy     out  high in every state except IDLE
//   done     out  one-cycle pulse when d/valid/gcd_out update
//   valid    out  1 = inverse exists (gcd == 1 and phi >= 2)
//   d        out  [W-1:0] inverse in [0, phi-1]; 0 when valid = 0
//   gcd_out  out  [W-1:0] gcd(e, phi) of the last operation
//   cycles   out  [15:0] latency of the last operation (only with
//                 MODINV_CYCLE_CNT_EN defined)
//
// Optional feature: define MODINV_CYCLE_CNT_EN to add the cycle counter.
// ---------------------------------------------------------------------------
module mod_inverse #(
    parameter int W  = 8,
    parameter int TW = W + 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] e,
    input  logic [W-1:0] phi,
    output logic         busy,
    output logic         done,
    output logic         valid,
    output logic [W-1:0] d,
`ifdef MODINV_CYCLE_CNT_EN
    output logic [15:0]  cycles,
`endif
    output logic [W-1:0] gcd_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SUB,
        S_SWAP,
        S_FIX,
        S_DONE
    } state_t;

    state_t               r_state;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_valid;
    logic [W-1:0]         r_d;
    logic [W-1:0]         r_gcd;

    // Remainders and Bezout coefficients. The invariant is r_i == t_i * e
    // (mod phi).
    logic [W-1:0]         r_r0;
    logic [W-1:0]         r_r1;
    logic signed [TW-1:0] r_t0;
    logic signed [TW-1:0] r_t1;
    logic [W-1:0]         r_phi_q;

    logic signed [TW-1:0] w_t0_plus_phi;
    logic [W-1:0]         w_d_fix;
    logic                 w_phi_lt2;
    logic                 w_r0_is_one;

    // |t0| <= phi, so a negative t0 plus phi lands in [0, phi-1].
    assign w_t0_plus_phi = r_t0 + $signed({{(TW-W){1'b0}}, r_phi_q});
    assign w_d_fix       = r_t0[TW-1] ? w_t0_plus_phi[W-1:0] : r_t0[W-1:0];
    assign w_phi_lt2     = (r_phi_q[W-1:1] == '0);
    assign w_r0_is_one   = (r_r0 == {{(W-1){1'b0}}, 1'b1});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_d     <= '0;
            r_gcd   <= '0;
            r_r0    <= '0;
            r_r1    <= '0;
            r_t0    <= '0;
            r_t1    <= '0;
            r_phi_q <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_r0    <= phi;
                        r_r1    <= e;
                        r_t0    <= '0;
                        r_t1    <= {{(TW-1){1'b0}}, 1'b1};
                        r_phi_q <= phi;
                        r_busy  <= 1'b1;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    // A modulus below 2 has no inverse. FIX forces valid
                    // low because it checks phi_q again.
                    if (w_phi_lt2 || (r_r1 == '0)) begin
                        r_state <= S_FIX;
                    end else begin
                        r_state <= S_SUB;
                    end
                end
                S_SUB: begin
                    if (r_r0 >= r_r1) begin
                        r_r0 <= r_r0 - r_r1;
                        r_t0 <= r_t0 - r_t1;
                    end else begin
                        r_state <= S_SWAP;
                    end
                end
                S_SWAP: begin
                    r_r0    <= r_r1;
                    r_r1    <= r_r0;
                    r_t0    <= r_t1;
                    r_t1    <= r_t0;
                    r_state <= S_CHECK;
                end
                S_FIX: begin
                    r_gcd <= r_r0;
                    if (!w_phi_lt2 && w_r0_is_one) begin
                        r_valid <= 1'b1;
                        r_d     <= w_d_fix;
                    end else begin
                        r_valid <= 1'b0;
                        r_d     <= '0;
                    end
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MODINV_CYCLE_CNT_EN
    logic [15:0] r_cycles;

    // The counter clears on an accepted start and counts CHECK..FIX. It
    // therefore holds the start-to-done distance from DONE until the
    // next start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycles <= '0;
        end else if (r_state == S_IDLE) begin
            if (start) begin
                r_cycles <= '0;
            end
        end else if (r_state != S_DONE) begin
            r_cycles <= r_cycles + 16'd1;
        end
    end

    assign cycles = r_cycles;
`endif

    assign busy    = r_busy;
    assign done    = r_done;
    assign valid   = r_valid;
    assign d       = r_d;
    assign gcd_out = r_gcd;

endmodule

// File: tb/tb_mod_inverse.sv
// ---------------------------------------------------------------------------
// tb_mod_inverse
// Directed plus exhaustive checks of mod_inverse. A scoreboard queue
// receives the expected result from a brute-force reference whenever a
// start is issued. The entry is popped and compared when done pulses.
// ---------------------------------------------------------------------------
module tb_mod_inverse;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] e;
    logic [7:0] phi;
    logic       busy;
    logic       done;
    logic       valid;
    logic [7:0] d;
    logic [7:0] gcd_out;
`ifdef MODINV_CYCLE_CNT_EN
    logic [15:0] cycles;
`endif

    mod_inverse #(.W(8), .TW(10)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .e       (e),
        .phi     (phi),
        .busy    (busy),
        .done    (done),
        .valid   (valid),
        .d       (d),
`ifdef MODINV_CYCLE_CNT_EN
        .cycles  (cycles),
`endif
        .gcd_out (gcd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] dd;
        logic [7:0] g;
        int         ea;
        int         pa;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cnt   = 0;

    localparam int TIMEOUT = 1000;

    // Reference: Euclid by division for the gcd, then a linear search for
    // the inverse.
    function automatic exp_t model(input int ea, input int pa);
        exp_t x;
        int   a;
        int   b;
        int   t;
        x.ea = ea;
        x.pa = pa;
        x.v  = 1'b0;
        x.dd = 8'd0;
        if (pa < 2) begin
            x.g = pa[7:0];
        end else begin
            a = ea;
            b = pa;
            while (b != 0) begin
                t = a % b;
                a = b;
                b = t;
            end
            x.g = a[7:0];
            if (a == 1) begin
                for (int k = 1; k < pa; k++) begin
                    if (((ea * k) % pa) == 1) begin
                        x.v  = 1'b1;
                        x.dd = k[7:0];
                        break;
                    end
                end
            end
        end
        return x;
    endfunction

    task automatic chk_bit(input string tag, input logic obs, input logic expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
        end
    endtask

    task automatic chk_byte(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Issue a start pulse and push the expected result.
    task automatic launch(input int ea, input int pa);
        e     = ea[7:0];
        phi   = pa[7:0];
        start = 1'b1;
        sb.push_back(model(ea, pa));
        @(negedge clk);
        start = 1'b0;
        cnt   = 1;
        chk_bit("busy_after_start", busy, 1'b1);
    endtask

    // Wait for done, bounded by a cycle budget, then compare against the
    // scoreboard head.
    task automatic finish(input int max_cyc);
        exp_t x;
        while (!done && cnt < TIMEOUT) begin
            @(negedge clk);
            cnt++;
        end
        x = sb.pop_front();
        if (!done) begin
            tests++;
            fails++;
            $error("FAIL timeout e=%0d phi=%0d observed=no_done expected=done", x.ea, x.pa);
        end else begin
            chk_bit("valid", valid, x.v);
            chk_byte("d", d, x.dd);
            chk_byte("gcd_out", gcd_out, x.g);
            tests++;
            assert (cnt <= max_cyc) else begin
                fails++;
                $error("FAIL latency observed=%0d expected<=%0d", cnt, max_cyc);
            end
`ifdef MODINV_CYCLE_CNT_EN
            tests++;
            assert (cycles === 16'(cnt - 1)) else begin
                fails++;
                $error("FAIL cycles observed=%0d expected=%0d", cycles, cnt - 1);
            end
`endif
            $display("[TB] e=%0d phi=%0d -> valid=%0b d=%0d gcd=%0d lat=%0d",
                     x.ea, x.pa, valid, d, gcd_out, cnt);
            @(negedge clk);
            chk_bit("done_one_cycle", done, 1'b0);
            chk_bit("busy_idle", busy, 1'b0);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        e     = 8'd0;
        phi   = 8'd0;
        repeat (3) @(negedge clk);
        // rst overrides start.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        chk_bit("rst_busy", busy, 1'b0);
        chk_bit("rst_done", done, 1'b0);
        chk_bit("rst_valid", valid, 1'b0);
        chk_byte("rst_d", d, 8'd0);
        chk_byte("rst_gcd", gcd_out, 8'd0);
`ifdef MODINV_CYCLE_CNT_EN
        tests++;
        assert (cycles === 16'd0) else begin
            fails++;
            $error("FAIL rst_cycles observed=%0d expected=0", cycles);
        end
`endif

        launch(3, 20);   finish(600);
        launch(7, 40);   finish(TIMEOUT);
        launch(23, 20);  finish(TIMEOUT);
        launch(4, 20);   finish(TIMEOUT);
        launch(0, 20);   finish(TIMEOUT);
        launch(1, 1);    finish(4);
        launch(1, 2);    finish(TIMEOUT);

        // A start while busy must be ignored. The result stays that of e=3.
        launch(3, 20);
        @(negedge clk);
        cnt++;
        e     = 8'd4;
        start = 1'b1;
        @(negedge clk);
        cnt++;
        start = 1'b0;
        finish(TIMEOUT);

        // A reset mid-operation aborts without a done pulse.
        launch(7, 40);
        repeat (4) begin
            @(negedge clk);
            chk_bit("no_done_before_rst", done, 1'b0);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        chk_bit("abort_busy", busy, 1'b0);
        chk_bit("abort_done", done, 1'b0);
        chk_bit("abort_valid", valid, 1'b0);
        chk_byte("abort_d", d, 8'd0);
        repeat (3) begin
            @(negedge clk);
            chk_bit("abort_no_done", done, 1'b0);
        end
        launch(7, 40);   finish(TIMEOUT);

        // Exhaustive sweep over e with phi=240.
        for (int k = 0; k < 256; k++) begin
            launch(k, 240);
            finish(TIMEOUT);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
